// File: rtl/ram32_loader.sv
// ram32_loader: collects a little-endian byte stream into 32-bit words and
// writes them to consecutive word addresses of a DEPTH-word memory, starting
// at a captured base address and stopping after a captured word count.
module ram32_loader #(
  parameter  int DEPTH      = 512,
  localparam int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  input  logic [ADDR_WIDTH-1:0] i_base_addr,
  input  logic [ADDR_WIDTH:0]   i_num_words,
  input  logic                  i_byte_valid,
  input  logic [7:0]            i_byte_data,
  output logic                  o_byte_ready,
  output logic                  o_we,
  output logic [ADDR_WIDTH-1:0] o_waddr,
  output logic [31:0]           o_wdata,
  output logic                  o_busy,
  output logic                  o_done
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_COLLECT = 2'd1;
  localparam logic [1:0] S_WRITE   = 2'd2;
  localparam logic [1:0] S_DONE    = 2'd3;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  logic [1:0]            state;
  logic [1:0]            byte_idx;
  logic [ADDR_WIDTH:0]   num_words;
  logic [ADDR_WIDTH:0]   word_cnt;
  logic [ADDR_WIDTH:0]   word_cnt_inc;
  logic [ADDR_WIDTH-1:0] addr;
  logic [31:0]           word;

  // Word counter after the write in progress; decides WRITE -> DONE/COLLECT.
  // NOTE: always_comb signals get a value on every path so no latch is inferred.
  always_comb begin
    word_cnt_inc = word_cnt + (ADDR_WIDTH + 1)'(1);
  end

  // Control FSM plus address, count and word-assembly registers.
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values and ordering inside the block is irrelevant.
  // NOTE: the partial-word register is reset too; a reset mid-word must not
  // leave stale bytes visible on o_wdata or merged into the next load.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state     <= S_IDLE;
      byte_idx  <= '0;
      word_cnt  <= '0;
      num_words <= '0;
      addr      <= '0;
      word      <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (i_start) begin
            addr      <= i_base_addr;
            num_words <= i_num_words;
            byte_idx  <= '0;
            word_cnt  <= '0;
            word      <= '0;
            state     <= (i_num_words == '0) ? S_DONE : S_COLLECT;
          end
        end
        S_COLLECT: begin
          if (i_byte_valid) begin
            // Shift in from the top: after four bytes, byte 0 sits in [7:0].
            word <= {i_byte_data, word[31:8]};
            if (byte_idx == 2'd3) begin
              byte_idx <= '0;
              state    <= S_WRITE;
            end else begin
              byte_idx <= byte_idx + 2'd1;
            end
          end
        end
        S_WRITE: begin
          addr     <= (addr == LAST_ADDR) ? '0 : addr + ADDR_WIDTH'(1);
          word_cnt <= word_cnt_inc;
          state    <= (word_cnt_inc == num_words) ? S_DONE : S_COLLECT;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Outputs decode directly from registered state; address and data are the
  // registers themselves, so all are glitch-free and zero while in IDLE.
  assign o_byte_ready = (state == S_COLLECT);
  assign o_we         = (state == S_WRITE);
  assign o_busy       = (state == S_COLLECT) || (state == S_WRITE);
  assign o_done       = (state == S_DONE);
  assign o_waddr      = addr;
  assign o_wdata      = word;

endmodule
